dac_stream_seq: RTL
===================

Name: dac_stream_seq

Overview:
- Parametrised successor to the single-channel core-to-DAC path: buffers samples produced by the core and paces them out to NUM_CH DAC channels at a programmable sample rate.
- Sits between the rvmyth core output and one or more avsddac instances in the SoC top.
- Supports round-robin multi-channel distribution or broadcast mode.
- Detects underflow and counts it.

Parameters:
- DW, 10, sample width in bits; matches the DAC input width.
- NUM_CH, 2, number of DAC channels driven (1..8).
- DEPTH, 8, FIFO depth in samples; must be a power of 2, ≥2.
- DIVW, 16, width of the rate divider.

Ports:
- clk_arun  in  1  system clock from the PLL.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DW  sample from the core.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a sample; equals !full.
- enable  in  1  run pacing; low forces IDLE.
- mode  in  1  0 = round-robin, 1 = broadcast.
- rate_div  in  DIVW  tick period minus 1; sampled every cycle.
- dac_out  out  NUM_CH*DW  channel c occupies bits [c*DW +: DW].
- dac_update  out  NUM_CH  one-cycle strobe per channel when its value changes.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- underflow_cnt  out  8  saturating count of starved ticks.

Behaviour:
- Reset (synchronous, active-high) sets all outputs to zero: dac_out, dac_update, fifo_level and underflow_cnt are 0, and in_ready is 1. It also sets state = IDLE, div_cnt = 0, ch_ptr = 0, and empties the FIFO.
- Reset is honoured mid-operation, and buffered samples are discarded.
- Push: occurs when in_valid && in_ready. A full FIFO blocks the push even when a pop happens in the same cycle.
- Push while the FIFO is empty does not fall through: data becomes poppable on the next cycle.
- FSM states: IDLE, RUN.
  - IDLE: div_cnt = 0 and ch_ptr = 0; no pops. Pushes are still accepted. Moves to RUN when enable = 1.
  - RUN: moves to IDLE when enable = 0. dac_out holds its last value in both states.
- Divider: in RUN, div_cnt increments each cycle. When div_cnt == rate_div, tick = 1 for that cycle and div_cnt wraps to 0.
  - rate_div = 0 produces a tick every cycle.
  - If rate_div is lowered below div_cnt, tick waits for div_cnt to wrap at 2^DIVW.
- On a tick with the FIFO non-empty: pop one sample.
  - Round-robin: dac_out[ch_ptr] is loaded at the next edge and dac_update[ch_ptr] = 1 in that same cycle. ch_ptr then advances, wrapping from NUM_CH-1 to 0.
  - Broadcast: all channels are loaded, all dac_update bits = 1, and ch_ptr is unchanged.
  - Latency: the new value is visible 1 cycle after the tick.
- On a tick with the FIFO empty: no update, ch_ptr is unchanged, and underflow_cnt increments, saturating at 255.
- Simultaneous push and pop on a non-full FIFO leaves the level unchanged.
- A mode change takes effect at the next tick. ch_ptr is not reset by a mode change.

Optional Feature:
- Macro: DAC_SLEW_LIMIT_EN.
- When defined:
  - Adds input slew_max[DW-1:0].
  - On each update, a channel moves toward the popped sample by at most slew_max per tick.
  - The remaining target is kept in a per-channel target register, and later ticks continue converging before the next pop for that channel is applied.
  - slew_max = 0 disables limiting.
- When undefined: direct load as described in Behaviour, and no slew_max port exists.

Decomposition:
- Package dac_stream_pkg holds:
  - state enum {IDLE, RUN};
  - constant MAX_CH = 8;
  - UF_CNT_W = 8;
  - helper function ptr_inc for wrap-around.
- One sub-module: dac_stream_fifo, a synchronous DEPTH×DW FIFO.
  - Ports: push, pop, din, dout, full, empty, level.
  - Uses the same clk_arun/reset.
- Pacing FSM and channel demux live in the top.

Test Plan:
1. Reset/basic: assert reset for 2 cycles → all outputs 0, in_ready = 1. Push 4, 3, 2, 1 with enable = 0 → fifo_level = 4, dac_out unchanged.
2. Round-robin: NUM_CH = 2, rate_div = 3, enable = 1, FIFO holds 0x100, 0x200, 0x300 → ticks every 4 cycles.
   - ch0 = 0x100, then ch1 = 0x200, then ch0 = 0x300.
   - Each update has a single-cycle dac_update strobe one cycle after its tick.
3. Underflow: FIFO empty, rate_div = 0, enable for 10 cycles → underflow_cnt = 10 and dac_out held. Run 300 empty ticks → underflow_cnt saturates at 255.
4. Full/backpressure: DEPTH = 8, enable = 0, push 9 samples → in_ready drops after the 8th, the 9th is held by the sender, and fifo_level = 8.
5. Broadcast + mid-run reset: mode = 1, pop 0x3FF → all channels = 0x3FF with all strobes. Assert reset during RUN with level 5 → level 0, dac_out 0, state IDLE.
6. Slew (DAC_SLEW_LIMIT_EN): slew_max = 0x40, ch0 at 0, pop 0x100 → ch0 reads 0x40, 0x80, 0xC0, 0x100 on successive ticks.

Source files
------------

// File: rtl/dac_stream_pkg.sv
// dac_stream_pkg
//   Shared types, constants and helpers for the DAC streaming sequencer.
//   - state_t  : pacing FSM states (IDLE, RUN)
//   - MAX_CH   : largest supported channel count
//   - PTR_W    : width of the channel pointer (covers MAX_CH channels)
//   - UF_CNT_W : width of the saturating underflow counter
//   - ptr_inc  : round-robin pointer advance with wrap at num_ch-1
package dac_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_CH   = 8;
  localparam int PTR_W    = 3;
  localparam int UF_CNT_W = 8;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                               input int unsigned     num_ch);
    if ({29'd0, ptr} + 32'd1 >= num_ch) return '0;
    return ptr + 3'd1;
  endfunction

endpackage

// File: rtl/dac_stream_fifo.sv
// dac_stream_fifo
//   Synchronous DEPTH x DW sample FIFO with show-ahead read data.
//   A push into an empty FIFO becomes visible (empty deasserts) on the
//   following cycle. A full FIFO refuses a push even when a pop happens in
//   the same cycle.
// Ports:
//   clk_arun, reset : clock, synchronous active-high reset (control only)
//   push, din       : write request and data
//   pop, dout       : read request; dout is the head entry (valid when !empty)
//   full, empty     : occupancy flags
//   level           : current occupancy, 0..DEPTH
import dac_stream_pkg::*;

module dac_stream_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk_arun,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd_ptr];

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk_arun) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is pure data: no reset, stale entries are never read while empty.
  always_ff @(posedge clk_arun) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/dac_stream_seq.sv
// dac_stream_seq
//   Buffers core samples in a FIFO and paces them out to NUM_CH DAC channels
//   at a programmable rate (tick every rate_div+1 cycles while running).
//   Round-robin mode loads one channel per tick; broadcast loads all.
//   A tick that finds the FIFO empty bumps a saturating underflow counter.
//   Optional macro DAC_SLEW_LIMIT_EN adds slew_max: each update moves a
//   channel by at most slew_max toward its target; channels still converging
//   consume ticks before the next sample is popped for them.
// Ports:
//   clk_arun, reset      : clock, synchronous active-high reset
//   in_data/in_valid     : sample stream from the core
//   in_ready             : FIFO not full
//   enable               : run pacing (low forces IDLE)
//   mode                 : 0 = round-robin, 1 = broadcast
//   rate_div             : tick period minus one
//   slew_max             : max step per tick, 0 = unlimited (macro only)
//   dac_out              : channel c at [c*DW +: DW]
//   dac_update           : per-channel one-cycle strobe on load
//   fifo_level           : FIFO occupancy
//   underflow_cnt        : saturating count of starved ticks
import dac_stream_pkg::*;

module dac_stream_seq #(
  parameter int DW     = 10,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int DIVW   = 16
) (
  input  logic                     clk_arun,
  input  logic                     reset,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [DIVW-1:0]          rate_div,
`ifdef DAC_SLEW_LIMIT_EN
  input  logic [DW-1:0]            slew_max,
`endif
  output logic [NUM_CH*DW-1:0]     dac_out,
  output logic [NUM_CH-1:0]        dac_update,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [UF_CNT_W-1:0]      underflow_cnt
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DIVW-1:0]     r_div_cnt;
  logic [PTR_W-1:0]    r_ch_ptr;
  logic [PTR_W-1:0]    w_ch_ptr_nxt;
  logic                w_tick_p0;
  logic                w_pop_p0;
  logic                w_uf_p0;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [DW-1:0]       w_fifo_dout;
  logic [DW-1:0]       r_dac_p1  [NUM_CH];
  logic [DW-1:0]       w_dac_nxt [NUM_CH];
  logic [NUM_CH-1:0]   r_upd_p1;
  logic [NUM_CH-1:0]   w_upd_nxt;
  logic [UF_CNT_W-1:0] r_uf_cnt;

  function automatic logic [UF_CNT_W-1:0] sat_inc(input logic [UF_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef DAC_SLEW_LIMIT_EN
  logic [DW-1:0]       r_tgt     [NUM_CH];
  logic [DW-1:0]       w_tgt_nxt [NUM_CH];
  logic                w_conv;

  // Step from cur toward tgt by at most lim; lim == 0 jumps straight there.
  function automatic logic [DW-1:0] slew_step(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] tgt,
                                              input logic [DW-1:0] lim);
    logic signed [DW:0] diff;
    logic signed [DW:0] slim;
    diff = signed'({1'b0, tgt}) - signed'({1'b0, cur});
    slim = signed'({1'b0, lim});
    if (lim == '0)   return tgt;
    if (diff > slim)  return cur + lim;
    if (diff < -slim) return cur - lim;
    return tgt;
  endfunction

  // A selected channel that has not reached its target blocks the next pop.
  always_comb begin
    w_conv = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((mode || ({29'd0, r_ch_ptr} == 32'(c))) && (r_dac_p1[c] != r_tgt[c]))
        w_conv = 1'b1;
    end
  end
`endif

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  dac_stream_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_arun (clk_arun),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop_p0),
    .din      (in_data),
    .dout     (w_fifo_dout),
    .full     (w_full),
    .empty    (w_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge clk_arun) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable)  w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: rate divider and tick ----
  // Equality compare: if rate_div drops below div_cnt the counter runs on
  // and wraps at 2^DIVW before the next tick.
  assign w_tick_p0 = (r_state == RUN) && (r_div_cnt == rate_div);

  always_ff @(posedge clk_arun) begin
    if (reset)                 r_div_cnt <= '0;
    else if (r_state != RUN)   r_div_cnt <= '0;
    else if (w_tick_p0)        r_div_cnt <= '0;
    else                       r_div_cnt <= r_div_cnt + 1'b1;
  end

  always_comb begin
    w_pop_p0     = 1'b0;
    w_uf_p0      = 1'b0;
    w_upd_nxt    = '0;
    w_ch_ptr_nxt = r_ch_ptr;
    for (int c = 0; c < NUM_CH; c++) w_dac_nxt[c] = r_dac_p1[c];
`ifdef DAC_SLEW_LIMIT_EN
    for (int c = 0; c < NUM_CH; c++) w_tgt_nxt[c] = r_tgt[c];
`endif
    if (r_state != RUN) begin
      w_ch_ptr_nxt = '0;
    end else if (w_tick_p0) begin
`ifdef DAC_SLEW_LIMIT_EN
      if (!w_conv && w_empty) begin
        w_uf_p0 = 1'b1;
      end else begin
        w_pop_p0 = !w_conv;
        for (int c = 0; c < NUM_CH; c++) begin
          if (mode || ({29'd0, r_ch_ptr} == 32'(c))) begin
            if (!w_conv) w_tgt_nxt[c] = w_fifo_dout;
            w_dac_nxt[c] = slew_step(r_dac_p1[c], w_tgt_nxt[c], slew_max);
            w_upd_nxt[c] = (w_dac_nxt[c] != r_dac_p1[c]);
            // Round-robin stays on a channel until it lands on its target.
            if (!mode && (w_dac_nxt[c] == w_tgt_nxt[c]))
              w_ch_ptr_nxt = ptr_inc(r_ch_ptr, NUM_CH);
          end
        end
      end
`else
      if (w_empty) begin
        w_uf_p0 = 1'b1;
      end else begin
        w_pop_p0 = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          if (mode || ({29'd0, r_ch_ptr} == 32'(c))) begin
            w_dac_nxt[c] = w_fifo_dout;
            w_upd_nxt[c] = 1'b1;
          end
        end
        if (!mode) w_ch_ptr_nxt = ptr_inc(r_ch_ptr, NUM_CH);
      end
`endif
    end
  end

  // ---- stage p1: registered channel outputs, one cycle after tick ----
  always_ff @(posedge clk_arun) begin
    if (reset) begin
      r_ch_ptr <= '0;
      r_upd_p1 <= '0;
      r_uf_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) r_dac_p1[c] <= '0;
`ifdef DAC_SLEW_LIMIT_EN
      for (int c = 0; c < NUM_CH; c++) r_tgt[c] <= '0;
`endif
    end else begin
      r_ch_ptr <= w_ch_ptr_nxt;
      r_upd_p1 <= w_upd_nxt;
      if (w_uf_p0) r_uf_cnt <= sat_inc(r_uf_cnt);
      for (int c = 0; c < NUM_CH; c++) r_dac_p1[c] <= w_dac_nxt[c];
`ifdef DAC_SLEW_LIMIT_EN
      for (int c = 0; c < NUM_CH; c++) r_tgt[c] <= w_tgt_nxt[c];
`endif
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign dac_out[g*DW +: DW] = r_dac_p1[g];
  end

  assign dac_update    = r_upd_p1;
  assign underflow_cnt = r_uf_cnt;

endmodule
